fetch_ctrl: RTL

Instruction-fetch sequencer for the pipelined MIPS core. It owns the fetch PC register and drives a request/acknowledge instruction-memory port. It holds one fetched instruction in an output buffer for the IF/ID stage. It applies decode-stage redirects (branch/jump targets from the decode-stage next-PC logic) with MIPS delay-slot semantics and honours the hazard unit's stall.

---
 rtl/fetch_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the pipelined MIPS core.
// Owns the fetch PC, drives a req/ack instruction-memory port, and holds one
// fetched instruction for IF/ID. Decode-stage redirects follow MIPS
// delay-slot semantics, and the hazard-unit stall is honoured.
// Optional feature macro: FETCH_PERF_EN (fetch / stall performance counters).
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_d,
  input  logic [31:0] npc_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ins_valid,
  output logic [31:0] ir_f,
  output logic [31:0] pc4_f,
  output logic        fetch_err,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        vld_q, vld_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc4_q, pc4_d;
  logic        err_q, err_d;

  logic        take;
  logic [31:0] tgt;
  logic        req;
  logic [31:0] addr;
  logic [31:0] addr_p4;
  logic        ack_v;

  assign take    = redirect_d & ~stall;
  assign tgt     = {npc_d[31:2], 2'b00};
  assign addr_p4 = addr + 32'd4;
  assign ack_v   = req & imem_ack;

  // Request/address decode; an outstanding FETCH address is never redirected,
  // and reset drops the request in the same cycle it is sampled.
  always_comb begin
    req  = 1'b0;
    addr = pc_q;
    case (state_q)
      FETCH: req = 1'b1;
      FULL: begin
        if (!stall) begin
          req = 1'b1;
          if (take) addr = tgt;
        end
      end
      default: ;
    endcase
    if (reset) req = 1'b0;
  end

  // Next-state, PC, pending-redirect and buffer computation.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    vld_d      = vld_q;
    ir_d       = ir_q;
    pc4_d      = pc4_q;
    err_d      = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (ack_v) begin
          state_d = FULL;
        end else if (take && !pend_q) begin
          // Outstanding fetch is the delay slot; remember where to go next.
          pend_d     = 1'b1;
          pend_tgt_d = tgt;
        end
        err_d = take & (|npc_d[1:0]) & (ack_v | ~pend_q);
      end
      FULL: begin
        if (!stall && !ack_v) begin
          vld_d   = 1'b0;
          state_d = FETCH;
          if (take) pc_d = tgt;
        end
        err_d = take & (|npc_d[1:0]);
      end
      default: state_d = IDLE;
    endcase

    if (ack_v) begin
      ir_d   = imem_rdata;
      pc4_d  = addr_p4;
      vld_d  = 1'b1;
      pend_d = 1'b0;
      if (state_q == FETCH && take) pc_d = tgt;
      else if (pend_q)              pc_d = pend_tgt_q;
      else                          pc_d = addr_p4;
    end
  end

  // State and buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'd0;
      vld_q      <= 1'b0;
      ir_q       <= 32'd0;
      pc4_q      <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      vld_q      <= vld_d;
      ir_q       <= ir_d;
      pc4_q      <= pc4_d;
      err_q      <= err_d;
    end
  end

  assign imem_req  = req;
  assign imem_addr = addr;
  assign ins_valid = vld_q;
  assign ir_f      = ir_q;
  assign pc4_f     = pc4_q;
  assign fetch_err = err_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Counter increments: accepted acks and stalled-valid cycles, wrapping.
  always_comb begin
    perf_fetch_d = perf_fetch_q + {31'd0, ack_v};
    perf_stall_d = perf_stall_q + {31'd0, vld_q & stall};
  end

  // Counter registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_q <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule
